mult_share_ctrl: RTL and testbench

Sequencing and arbitration controller that shares one combinational `multiplier #(SIZE)` array among NUM_REQ requesters. It grants one requester at a time, round-robin. It captures that requester's operands into registers and holds them stable for SETTLE cycles so the ripple array settles. It then registers the product and returns it with the requester's ID over a valid/ready response channel. It sits between client blocks and the single multiplier instance, which it instantiates internally.

---
 rtl/mult_share_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mult_share_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_ctrl.sv
// Round-robin controller that time-shares one combinational multiplier among NUM_REQ requesters.
// Operands are registered and held for SETTLE cycles before the product is captured and returned.

module multiplier #(
    parameter int SIZE = 4
) (
    input  logic [SIZE-1:0]   x,
    input  logic [SIZE-1:0]   y,
    output logic [2*SIZE-1:0] p
);
    // Unsigned shift-and-add array: one partial-product row per bit of y.
    always_comb begin
        p = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (y[i]) p = p + ({{SIZE{1'b0}}, x} << i);
        end
    end
endmodule

module mult_share_ctrl #(
    parameter  int SIZE    = 4,
    parameter  int NUM_REQ = 4,
    parameter  int SETTLE  = 2,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*SIZE-1:0] req_x,
    input  logic [NUM_REQ*SIZE-1:0] req_y,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    resp_valid,
    output logic [IDW-1:0]          resp_id,
    output logic [2*SIZE-1:0]       resp_p,
    input  logic                    resp_ready,
    output logic                    busy
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SIZE-1:0]   x_q, x_d, y_q, y_d;
    logic [IDW-1:0]    id_q, id_d, last_q, last_d, resp_id_q, resp_id_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              resp_valid_q, resp_valid_d;
    logic [2*SIZE-1:0] resp_p_q, resp_p_d, mult_p;
    logic              grant_found;
    logic [IDW-1:0]    grant_idx, cand;
    logic [SIZE-1:0]   x_sel, y_sel;

    multiplier #(.SIZE(SIZE)) u_mult (
        .x(x_q),
        .y(y_q),
        .p(mult_p)
    );

    // Rotating priority: the search starts one past the most recently granted index.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((int'(last_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        x_sel = '0;
        y_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                x_sel = req_x[i*SIZE +: SIZE];
                y_sel = req_y[i*SIZE +: SIZE];
            end
        end
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid and payload are held until then, and ready may depend combinationally on valid.
    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && grant_found) req_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        id_d         = id_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q;
        resp_p_d     = resp_p_q;
        resp_id_d    = resp_id_q;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    x_d     = x_sel;
                    y_d     = y_sel;
                    id_d    = grant_idx;
                    last_d  = grant_idx;
                    cnt_d   = CW'(SETTLE - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    resp_p_d     = mult_p;
                    resp_id_d    = id_q;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            id_q         <= '0;
            last_q       <= IDW'(NUM_REQ - 1);
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_p_q     <= '0;
            resp_id_q    <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            id_q         <= id_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_p_q     <= resp_p_d;
            resp_id_q    <= resp_id_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_p     = resp_p_q;
    assign resp_id    = resp_id_q;
    assign busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: timeline model with per-cycle compare plus directed literal checks.

module tb_mult_share_ctrl;
    localparam int SIZE   = 4;
    localparam int N      = 4;
    localparam int SETTLE = 2;
    localparam int IDW    = 2;
    localparam int PW     = 2 * SIZE;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N*SIZE-1:0] req_x;
    logic [N*SIZE-1:0] req_y;
    logic [N-1:0]      req_ready;
    logic              resp_valid;
    logic [IDW-1:0]    resp_id;
    logic [PW-1:0]     resp_p;
    logic              resp_ready;
    logic              busy;

    int checks = 0;
    int errors = 0;

    mult_share_ctrl #(.SIZE(SIZE), .NUM_REQ(N), .SETTLE(SETTLE)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_x(req_x),
        .req_y(req_y),
        .req_ready(req_ready),
        .resp_valid(resp_valid),
        .resp_id(resp_id),
        .resp_p(resp_p),
        .resp_ready(resp_ready),
        .busy(busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        int i;
        for (int k = 1; k <= N; k++) begin
            i = (last + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // ---------------- behavioural model ----------------
    // A transaction is described by its age in cycles since the accept edge.
    logic [IDW+PW-1:0] exp_q[$];
    bit                m_init = 1'b0;
    bit                m_active = 1'b0;
    int                m_age = 0;
    int                m_last = N - 1;
    logic [PW-1:0]     m_p = '0;
    logic [IDW-1:0]    m_id = '0;
    logic [PW-1:0]     xe, ye;
    int                g, g2;
    logic [N-1:0]      exp_ready;

    always @(posedge clk) begin
        if (reset) begin
            m_init   = 1'b1;
            m_active = 1'b0;
            m_age    = 0;
            m_last   = N - 1;
            m_p      = '0;
            m_id     = '0;
            exp_q.delete();
        end else if (m_init) begin
            if (!m_active) begin
                g = rr_pick(req_valid, m_last);
                if (g >= 0) begin
                    xe = PW'(req_x[g*SIZE +: SIZE]);
                    ye = PW'(req_y[g*SIZE +: SIZE]);
                    exp_q.push_back({IDW'(g), xe * ye});
                    m_last   = g;
                    m_active = 1'b1;
                    m_age    = 1;
                end
            end else if (m_age >= SETTLE + 1) begin
                if (resp_ready) m_active = 1'b0;
            end else begin
                m_age++;
                if (m_age == SETTLE + 1 && exp_q.size() > 0) {m_id, m_p} = exp_q.pop_front();
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_init) begin
            g2 = rr_pick(req_valid, m_last);
            exp_ready = (!m_active && g2 >= 0) ? (N'(1) << g2) : '0;
            check("cyc_req_ready", req_ready, exp_ready);
            check("cyc_resp_valid", resp_valid, m_active && (m_age >= SETTLE + 1));
            check("cyc_busy", busy, m_active);
            check("cyc_resp_p", resp_p, m_p);
            check("cyc_resp_id", resp_id, m_id);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int id, input logic [SIZE-1:0] x, input logic [SIZE-1:0] y);
        req_x[id*SIZE +: SIZE] = x;
        req_y[id*SIZE +: SIZE] = y;
    endtask

    task automatic wait_grant(input int id, output int n);
        n = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (req_ready[id] === 1'b1) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic do_txn(input int id, input logic [SIZE-1:0] x, input logic [SIZE-1:0] y,
                          output logic [PW-1:0] p, output int rid, output int lat);
        int gw;
        set_op(id, x, y);
        req_valid[id] = 1'b1;
        wait_grant(id, gw);
        check("grant_wait", gw, 1);
        tick();
        req_valid[id] = 1'b0;
        wait_resp(lat);
        p   = resp_p;
        rid = int'(resp_id);
        tick();
    endtask

    // ---------------- directed sequence ----------------
    int            exp_ord[5] = '{0, 1, 2, 3, 0};
    int            exp_prd[5] = '{20, 42, 99, 182, 20};
    int            grant_ord[5];
    int            grant_cyc[5];
    int            r_id[5];
    logic [PW-1:0] r_p[5];
    int            g_cnt, r_cnt, gw, lat, rid;
    logic [PW-1:0] p;

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_x      = '0;
        req_y      = '0;
        resp_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_p", resp_p, 0);
        check("rst_resp_id", resp_id, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 0);
        tick();

        // single request
        do_txn(0, 4'd3, 4'd5, p, rid, lat);
        check("t2_latency", lat, 3);
        check("t2_p", p, 15);
        check("t2_id", rid, 0);

        // extreme operands
        do_txn(2, 4'd15, 4'd15, p, rid, lat);
        check("t3_max_p", p, 225);
        check("t3_max_id", rid, 2);
        do_txn(2, 4'd0, 4'd9, p, rid, lat);
        check("t3_zero_p", p, 0);
        check("t3_zero_lat", lat, 3);

        // round robin with every requester pending
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_op(0, 4'd4, 4'd5);
        set_op(1, 4'd6, 4'd7);
        set_op(2, 4'd9, 4'd11);
        set_op(3, 4'd13, 4'd14);
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            grant_ord[k] = -1;
            grant_cyc[k] = 0;
            r_id[k]      = -1;
            r_p[k]       = '0;
        end
        g_cnt = 0;
        r_cnt = 0;
        for (int c = 0; c < 60 && r_cnt < 5; c++) begin
            @(negedge clk);
            if (req_ready != '0 && g_cnt < 5) begin
                grant_ord[g_cnt] = onehot_idx(req_ready);
                grant_cyc[g_cnt] = c;
                g_cnt++;
            end
            if (resp_valid === 1'b1 && r_cnt < 5) begin
                r_id[r_cnt] = int'(resp_id);
                r_p[r_cnt]  = resp_p;
                r_cnt++;
            end
            tick();
            if (g_cnt == 5) req_valid = '0;
        end
        check("t4_grant_count", g_cnt, 5);
        check("t4_resp_count", r_cnt, 5);
        for (int k = 0; k < 5; k++) begin
            check("t4_grant_order", grant_ord[k], exp_ord[k]);
            check("t4_resp_id", r_id[k], exp_ord[k]);
            check("t4_resp_p", r_p[k], exp_prd[k]);
        end
        for (int k = 0; k < 4; k++) begin
            check("t4_accept_spacing", grant_cyc[k+1] - grant_cyc[k], 4);
        end

        // backpressure
        resp_ready = 1'b0;
        set_op(3, 4'd11, 4'd12);
        req_valid[3] = 1'b1;
        wait_grant(3, gw);
        check("t5_grant_wait", gw, 1);
        tick();
        req_valid[3] = 1'b0;
        wait_resp(lat);
        check("t5_latency", lat, 3);
        check("t5_p", resp_p, 132);
        check("t5_id", resp_id, 3);
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 0) begin
                set_op(1, 4'd2, 4'd3);
                req_valid[1] = 1'b1;
            end
            @(negedge clk);
            check("t5_hold_valid", resp_valid, 1);
            check("t5_hold_p", resp_p, 132);
            check("t5_hold_id", resp_id, 3);
            check("t5_hold_ready", req_ready, 0);
        end
        tick();
        resp_ready = 1'b1;
        @(negedge clk);
        check("t5_valid_before_edge", resp_valid, 1);
        tick();
        @(negedge clk);
        check("t5_idle_valid", resp_valid, 0);
        check("t5_idle_busy", busy, 0);
        check("t5_next_ready", req_ready, 4'b0010);
        tick();
        req_valid[1] = 1'b0;
        wait_resp(lat);
        check("t5_next_latency", lat, 3);
        check("t5_next_p", resp_p, 6);
        check("t5_next_id", resp_id, 1);
        tick();

        // abort during WAIT
        set_op(0, 4'd7, 4'd6);
        req_valid[0] = 1'b1;
        wait_grant(0, gw);
        check("t6_grant_wait", gw, 1);
        tick();
        req_valid[0] = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t6_no_resp", resp_valid, 0);
            check("t6_not_busy", busy, 0);
            tick();
        end
        do_txn(1, 4'd2, 4'd4, p, rid, lat);
        check("t6_p", p, 8);
        check("t6_id", rid, 1);
        check("t6_latency", lat, 3);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- final report on a stuck run ----------------
    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout: got no completion, expected finish before %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
